// File: rtl/collision_player_objects_mc.sv
// Player-vs-N-object collision detector.
// Registers at most one hit per frame, then holds off further hits for a
// frame-counted cooldown. Also reports which object hit, keeps a saturating
// hit count, and gives a snapshot of per-object overlaps from the previous
// frame.
module collision_player_objects_mc #(
    parameter int unsigned NUM_OBJ         = 8,
    parameter int unsigned IDX_W           = 3,
    parameter int unsigned COOLDOWN_FRAMES = 16,
    parameter int unsigned CD_W            = 5,
    parameter int unsigned CNT_W           = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               playerDrawingRequest,
    input  logic [NUM_OBJ-1:0] objDrawingRequest,
    input  logic [NUM_OBJ-1:0] objEnable,
    output logic               SingleHitPulse,
    output logic [IDX_W-1:0]   hitIndex,
    output logic [CNT_W-1:0]   hitCount,
    output logic               invulnerable,
    output logic [NUM_OBJ-1:0] frameHitMask
);

    // Value loaded into the cooldown counter when leaving LOCKED. When the
    // cooldown is zero frames, the counter is never used.
    localparam int unsigned CD_LOAD = (COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        LOCKED   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t             state;
    state_t             mid_state;
    state_t             state_next;
    logic [CD_W-1:0]    cd_cnt;
    logic [CD_W-1:0]    cd_next;
    logic [NUM_OBJ-1:0] ov;
    logic [NUM_OBJ-1:0] acc;
    logic               collision;
    logic               hit;
    logic [IDX_W-1:0]   low_idx;

    // Per-object overlap, qualified by the player pixel and the object enable.
    assign ov        = {NUM_OBJ{playerDrawingRequest}} & objDrawingRequest & objEnable;
    assign collision = |ov;

    // Find the lowest-index overlapping object. The loop scans downwards,
    // so the last match written is the lowest index.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (ov[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // Step 1 handles the frame boundary; step 2 arms the hit from the
    // resulting state. This lets a collision on the frame-start cycle count
    // for the new frame.
    always_comb begin
        mid_state = state;
        cd_next   = cd_cnt;
        if (startOfFrame) begin
            case (state)
                LOCKED: begin
                    if (COOLDOWN_FRAMES == 0) begin
                        mid_state = ARMED;
                    end else begin
                        mid_state = COOLDOWN;
                        cd_next   = CD_W'(CD_LOAD);
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt == '0) begin
                        mid_state = ARMED;
                    end else begin
                        cd_next = cd_cnt - CD_W'(1);
                    end
                end
                default: mid_state = state;
            endcase
        end
        hit        = (mid_state == ARMED) && collision;
        state_next = hit ? LOCKED : mid_state;
    end

    // State and cooldown counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ARMED;
            cd_cnt <= '0;
        end else begin
            state  <= state_next;
            cd_cnt <= cd_next;
        end
    end

    // Registered outputs: hit pulse, hit record, invulnerability and overlap snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            SingleHitPulse <= 1'b0;
            hitIndex       <= '0;
            hitCount       <= '0;
            invulnerable   <= 1'b0;
            frameHitMask   <= '0;
            acc            <= '0;
        end else begin
            SingleHitPulse <= hit;
            invulnerable   <= (state_next != ARMED);
            if (hit) begin
                hitIndex <= low_idx;
                if (hitCount != {CNT_W{1'b1}}) begin
                    hitCount <= hitCount + CNT_W'(1);
                end
            end
            if (startOfFrame) begin
                frameHitMask <= acc;
                acc          <= ov;
            end else begin
                acc <= acc | ov;
            end
        end
    end

endmodule

// File: tb/tb_collision_player_objects_mc.sv
// Directed bench for collision_player_objects_mc. Three instances share the
// same stimulus:
//   dut_a - cooldown of 2 frames, 8-bit hit counter
//   dut_b - no cooldown
//   dut_c - cooldown of 2 frames, 2-bit saturating hit counter
module tb_collision_player_objects_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic       sof;
    logic       pdr;
    logic [7:0] odr;
    logic [7:0] en;

    logic       pulse_a, pulse_b, pulse_c;
    logic [2:0] idx_a, idx_b, idx_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       inv_a, inv_b, inv_c;
    logic [7:0] mask_a, mask_b, mask_c;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    collision_player_objects_mc #(
        .NUM_OBJ(8), .IDX_W(3), .COOLDOWN_FRAMES(2), .CD_W(5), .CNT_W(8)
    ) dut_a (
        .clk(clk), .reset(reset), .startOfFrame(sof), .playerDrawingRequest(pdr),
        .objDrawingRequest(odr), .objEnable(en), .SingleHitPulse(pulse_a),
        .hitIndex(idx_a), .hitCount(cnt_a), .invulnerable(inv_a), .frameHitMask(mask_a)
    );

    collision_player_objects_mc #(
        .NUM_OBJ(8), .IDX_W(3), .COOLDOWN_FRAMES(0), .CD_W(5), .CNT_W(8)
    ) dut_b (
        .clk(clk), .reset(reset), .startOfFrame(sof), .playerDrawingRequest(pdr),
        .objDrawingRequest(odr), .objEnable(en), .SingleHitPulse(pulse_b),
        .hitIndex(idx_b), .hitCount(cnt_b), .invulnerable(inv_b), .frameHitMask(mask_b)
    );

    collision_player_objects_mc #(
        .NUM_OBJ(8), .IDX_W(3), .COOLDOWN_FRAMES(2), .CD_W(5), .CNT_W(2)
    ) dut_c (
        .clk(clk), .reset(reset), .startOfFrame(sof), .playerDrawingRequest(pdr),
        .objDrawingRequest(odr), .objEnable(en), .SingleHitPulse(pulse_c),
        .hitIndex(idx_c), .hitCount(cnt_c), .invulnerable(inv_c), .frameHitMask(mask_c)
    );

    // Count one comparison and report it if the values differ.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle. Inputs are driven at the negedge, and outputs are
    // valid at the following negedge.
    task automatic step(input logic s, input logic [7:0] o);
        sof = s;
        pdr = (o != 8'h00);
        odr = o;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Apply a two-cycle reset while an overlap and a frame start are
    // present, to confirm that reset takes priority over both.
    task automatic do_reset();
        reset = 1'b1;
        step(1'b1, 8'h01);
        step(1'b0, 8'h01);
        reset = 1'b0;
        sof = 1'b0; pdr = 1'b0; odr = 8'h00;
    endtask

    // One frame: a start-of-frame cycle, then three cycles of overlap `o`.
    // Returns the number of hit pulses seen on dut_a and dut_b.
    task automatic run_frame(input logic [7:0] o, output int pa, output int pb);
        pa = 0; pb = 0;
        step(1'b1, 8'h00);
        pa += int'(pulse_a); pb += int'(pulse_b);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, o);
            pa += int'(pulse_a); pb += int'(pulse_b);
        end
    endtask

    initial begin
        int pa, pb;
        reset = 1'b1; sof = 1'b0; pdr = 1'b0; odr = 8'h00; en = 8'hFF;
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_pulse", 32'(pulse_a), 32'd0);
        check("rst_cnt",   32'(cnt_a),   32'd0);
        check("rst_inv",   32'(inv_a),   32'd0);
        check("rst_mask",  32'(mask_a),  32'd0);

        // Test 1: obj3 overlaps for 5 cycles in mid-frame
        step(1'b1, 8'h00);
        step(1'b0, 8'h00);
        step(1'b0, 8'h08);
        check("t1_pulse", 32'(pulse_a), 32'd1);
        check("t1_idx",   32'(idx_a),   32'd3);
        check("t1_cnt",   32'(cnt_a),   32'd1);
        check("t1_inv",   32'(inv_a),   32'd1);
        step(1'b0, 8'h08);
        check("t1_pulse_once", 32'(pulse_a), 32'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 8'h08);
        check("t1_cnt_hold", 32'(cnt_a), 32'd1);
        check("t1_no_extra", 32'(pulse_a), 32'd0);
        step(1'b0, 8'h00);

        // Test 2: obj5 and obj2 overlap together; the lowest index wins
        do_reset();
        step(1'b1, 8'h00);
        step(1'b0, 8'h24);
        check("t2_idx",   32'(idx_a),   32'd2);
        check("t2_pulse", 32'(pulse_a), 32'd1);
        step(1'b0, 8'h00);
        step(1'b1, 8'h00);
        check("t2_mask", 32'(mask_a), 32'h24);
        step(1'b1, 8'h00);
        check("t2_mask_clr", 32'(mask_a), 32'h00);

        // Test 3: overlap in every frame (cooldown of 2 frames vs. no cooldown)
        do_reset();
        run_frame(8'h01, pa, pb);
        check("t3_f1_a", 32'(pa), 32'd1);
        check("t3_f1_b", 32'(pb), 32'd1);
        run_frame(8'h01, pa, pb);
        check("t3_f2_a", 32'(pa), 32'd0);
        check("t3_f2_b", 32'(pb), 32'd1);
        check("t3_f2_inv", 32'(inv_a), 32'd1);
        run_frame(8'h01, pa, pb);
        check("t3_f3_a", 32'(pa), 32'd0);
        check("t3_f3_b", 32'(pb), 32'd1);
        run_frame(8'h01, pa, pb);
        check("t3_f4_a", 32'(pa), 32'd1);
        check("t3_f4_b", 32'(pb), 32'd1);

        // Test 4: collision on the start-of-frame cycle while LOCKED
        step(1'b1, 8'h01);
        check("t4_pulse_c0", 32'(pulse_b), 32'd1);
        check("t4_cnt_c0",   32'(cnt_b),   32'd5);
        check("t4_pulse_c2", 32'(pulse_a), 32'd0);
        check("t4_cnt_c2",   32'(cnt_a),   32'd2);
        step(1'b0, 8'h00);

        // Test 5: enable masking, plus a player-absent case
        do_reset();
        en = 8'hEF;
        step(1'b1, 8'h00);
        step(1'b0, 8'h10);
        check("t5_masked_pulse", 32'(pulse_a), 32'd0);
        sof = 1'b0; pdr = 1'b0; odr = 8'hFF;
        @(posedge clk); @(negedge clk);
        check("t5_no_player", 32'(pulse_a), 32'd0);
        step(1'b1, 8'h00);
        check("t5_mask4", 32'(mask_a), 32'h00);
        check("t5_inv",   32'(inv_a),  32'd0);
        en = 8'hFF;
        step(1'b0, 8'h10);
        check("t5_pulse", 32'(pulse_a), 32'd1);
        check("t5_idx",   32'(idx_a),   32'd4);
        step(1'b1, 8'h00);
        check("t5_mask_on", 32'(mask_a), 32'h10);

        // Test 6: saturating 2-bit counter, then reset during cooldown
        do_reset();
        for (int h = 1; h <= 5; h++) begin
            run_frame(8'h02, pa, pb);
            check("t6_cnt_sat", 32'(cnt_c), (h >= 3) ? 32'd3 : 32'(h));
            check("t6_cnt_wide", 32'(cnt_a), 32'(h));
            run_frame(8'h00, pa, pb);
            run_frame(8'h00, pa, pb);
        end
        run_frame(8'h02, pa, pb);
        check("t6_pulse_sat", 32'(pa), 32'd1);
        run_frame(8'h00, pa, pb);
        check("t6_inv_cd",  32'(inv_c),  32'd1);
        check("t6_mask_pre", 32'(mask_c), 32'h02);
        do_reset();
        check("t6_rst_pulse", 32'(pulse_c), 32'd0);
        check("t6_rst_cnt",   32'(cnt_c),   32'd0);
        check("t6_rst_inv",   32'(inv_c),   32'd0);
        check("t6_rst_idx",   32'(idx_c),   32'd0);
        check("t6_rst_mask",  32'(mask_c),  32'h00);
        step(1'b0, 8'h02);
        check("t6_post_pulse", 32'(pulse_c), 32'd1);
        check("t6_post_cnt",   32'(cnt_c),   32'd1);
        check("t6_post_idx",   32'(idx_c),   32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
